// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and bus constants for the two-master memory bus arbiter.
// Both masters and the slave use the same read/write/waitrequest protocol.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] ABORT_READDATA = 32'h0000_0000;

    // One-hot owner encoding as seen on the debug grant output
    function automatic logic [1:0] grant_of(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        if (s == GRANT0) g = 2'b01;
        if (s == GRANT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave between the CPU (master 0)
// and a secondary master (master 1), with a stall timeout and sticky error.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,

    output logic              bus_error,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_t       state;
    logic             last_grant;
    logic [CNT_W-1:0] stall_cnt;

    logic req0;
    logic req1;
    logic owner_req;
    logic stall_limit;
    logic abort_now;
    logic xfer_end;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        owner_req = 1'b0;
        case (state)
            GRANT0:  owner_req = req0;
            GRANT1:  owner_req = req1;
            default: owner_req = 1'b0;
        endcase
    end

    // An abort cycle stands in for the completion the slave never gave
    assign stall_limit = (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign abort_now   = owner_req & s_waitrequest & stall_limit;
    assign xfer_end    = owner_req & (~s_waitrequest | abort_now);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            stall_cnt  <= '0;
            bus_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (req0 && (!req1 || last_grant)) begin
                        state <= GRANT0;
                        grant <= grant_of(GRANT0);
                    end else if (req1) begin
                        state <= GRANT1;
                        grant <= grant_of(GRANT1);
                    end
                end

                GRANT0: begin
                    if (!req0) begin
                        state      <= IDLE;
                        grant      <= grant_of(IDLE);
                        last_grant <= 1'b0;
                        stall_cnt  <= '0;
                    end else if (xfer_end) begin
                        last_grant <= 1'b0;
                        stall_cnt  <= '0;
                        if (abort_now) bus_error <= 1'b1;
                        if (req1) begin
                            state <= GRANT1;
                            grant <= grant_of(GRANT1);
                        end else begin
                            state <= IDLE;
                            grant <= grant_of(IDLE);
                        end
                    end else if (s_waitrequest) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end

                GRANT1: begin
                    if (!req1) begin
                        state      <= IDLE;
                        grant      <= grant_of(IDLE);
                        last_grant <= 1'b1;
                        stall_cnt  <= '0;
                    end else if (xfer_end) begin
                        last_grant <= 1'b1;
                        stall_cnt  <= '0;
                        if (abort_now) bus_error <= 1'b1;
                        if (req0) begin
                            state <= GRANT0;
                            grant <= grant_of(GRANT0);
                        end else begin
                            state <= IDLE;
                            grant <= grant_of(IDLE);
                        end
                    end else if (s_waitrequest) begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= grant_of(IDLE);
                end
            endcase
        end
    end

    // The owner talks straight to the slave; the loser is parked
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (state)
            GRANT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~abort_now;
                s_write        = m0_write & ~abort_now;
                m0_waitrequest = s_waitrequest & ~abort_now;
                m0_readdata    = abort_now ? ABORT_READDATA : s_readdata;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~abort_now;
                s_write        = m1_write & ~abort_now;
                m1_waitrequest = s_waitrequest & ~abort_now;
                m1_readdata    = abort_now ? ABORT_READDATA : s_readdata;
            end
            default: begin
                s_read = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(grant));
    a_grant_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
        grant == grant_of(state));
    a_slave_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(s_read && s_write));
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: ownership-level reference model,
// simple wait-state slave memory, and directed scenarios with literal checks.
module tb_mem_bus_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] m0_address = '0, m1_address = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata;
    logic        s_read, s_write;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        bus_error;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .bus_error(bus_error), .grant(grant)
    );

    always #5 clk = ~clk;

    // Slave: unwritten words read back as A500_0000 | address
    logic [31:0] mem [64];
    bit          written [64];
    int          waited = 0;
    int          wait_cfg = 0;
    bit          stall_all = 1'b0;

    always_comb s_waitrequest = stall_all || (waited < wait_cfg);
    always_comb s_readdata = written[s_address[7:2]] ? mem[s_address[7:2]]
                                                     : (32'hA500_0000 | s_address);

    always @(posedge clk) begin
        if (s_read || s_write) begin
            if (!s_waitrequest) begin
                waited <= 0;
                if (s_write) begin
                    mem[s_address[7:2]]     <= s_writedata;
                    written[s_address[7:2]] <= 1'b1;
                end
            end else begin
                waited <= waited + 1;
            end
        end else begin
            waited <= 0;
        end
    end

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return written[a[7:2]] ? mem[a[7:2]] : (32'hA500_0000 | a);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus, who went last, how long it has stalled
    int m_owner = -1;
    int m_last = 1;
    int m_stall = 0;
    bit m_err = 1'b0;
    int cyc = 0;
    int other;
    bit done0, done1;
    logic rq0, rq1, oreq, ab;
    logic e_sr, e_sw, e_mw0, e_mw1;
    logic [1:0] e_grant;
    logic [31:0] e_sa, e_swd, e_rd0, e_rd1;
    logic [3:0] e_be;

    typedef struct { int m; int cyc; logic [31:0] data; } comp_t;
    comp_t comp[$];

    always @(negedge clk) begin
        cyc++;
        rq0 = m0_read | m0_write;
        rq1 = m1_read | m1_write;
        if (!reset_n) begin
            m_owner = -1; m_last = 1; m_stall = 0; m_err = 1'b0;
        end
        oreq = (m_owner == 0) ? rq0 : (m_owner == 1) ? rq1 : 1'b0;
        ab = oreq && s_waitrequest && (m_stall == TO - 1);

        e_grant = 2'b00; e_sr = 0; e_sw = 0; e_sa = 0; e_swd = 0; e_be = 0;
        e_mw0 = 1; e_mw1 = 1; e_rd0 = 0; e_rd1 = 0;
        if (m_owner == 0) begin
            e_grant = 2'b01; e_sa = m0_address; e_swd = m0_writedata; e_be = m0_byteenable;
            e_sr = m0_read && !ab; e_sw = m0_write && !ab;
            e_mw0 = ab ? 1'b0 : s_waitrequest;
            e_rd0 = ab ? 32'h0 : slave_word(m0_address);
        end else if (m_owner == 1) begin
            e_grant = 2'b10; e_sa = m1_address; e_swd = m1_writedata; e_be = m1_byteenable;
            e_sr = m1_read && !ab; e_sw = m1_write && !ab;
            e_mw1 = ab ? 1'b0 : s_waitrequest;
            e_rd1 = ab ? 32'h0 : slave_word(m1_address);
        end

        check_output("grant", 32'(grant), 32'(e_grant));
        check_output("bus_error", 32'(bus_error), 32'(m_err));
        check_output("s_read", 32'(s_read), 32'(e_sr));
        check_output("s_write", 32'(s_write), 32'(e_sw));
        check_output("s_address", s_address, e_sa);
        check_output("s_writedata", s_writedata, e_swd);
        check_output("s_byteenable", 32'(s_byteenable), 32'(e_be));
        check_output("m0_waitrequest", 32'(m0_waitrequest), 32'(e_mw0));
        check_output("m1_waitrequest", 32'(m1_waitrequest), 32'(e_mw1));
        check_output("m0_readdata", m0_readdata, e_rd0);
        check_output("m1_readdata", m1_readdata, e_rd1);

        done0 = rq0 && !m0_waitrequest;
        done1 = rq1 && !m1_waitrequest;
        if (done0) comp.push_back('{0, cyc, m0_readdata});
        if (done1) comp.push_back('{1, cyc, m1_readdata});

        if (reset_n) begin
            if (m_owner < 0) begin
                m_stall = 0;
                if (rq0 && rq1) m_owner = 1 - m_last;
                else if (rq0) m_owner = 0;
                else if (rq1) m_owner = 1;
            end else if (!oreq) begin
                m_last = m_owner; m_owner = -1; m_stall = 0;
            end else if (!s_waitrequest || ab) begin
                other = 1 - m_owner;
                if (ab) m_err = 1'b1;
                m_last = m_owner;
                m_owner = ((other == 0) ? rq0 : rq1) ? other : -1;
                m_stall = 0;
            end else begin
                m_stall++;
            end
        end
    end

    // Transaction engine: each master holds a request until it sees waitrequest low
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } xfer_t;
    xfer_t q0[$], q1[$];
    bit act0 = 1'b0, act1 = 1'b0;

    task automatic add_xfer(input int m, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.data = data;
        if (m == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    task automatic drive0(input bit en, input xfer_t x);
        m0_read = en && !x.wr; m0_write = en && x.wr;
        m0_address = en ? x.addr : 32'h0; m0_writedata = en ? x.data : 32'h0;
        m0_byteenable = en ? 4'hF : 4'h0;
    endtask

    task automatic drive1(input bit en, input xfer_t x);
        m1_read = en && !x.wr; m1_write = en && x.wr;
        m1_address = en ? x.addr : 32'h0; m1_writedata = en ? x.data : 32'h0;
        m1_byteenable = en ? 4'hF : 4'h0;
    endtask

    task automatic engine_tick();
        xfer_t nox;
        nox.wr = 1'b0; nox.addr = '0; nox.data = '0;
        if (done0 && act0) begin void'(q0.pop_front()); act0 = 1'b0; end
        if (done1 && act1) begin void'(q1.pop_front()); act1 = 1'b0; end
        if (!act0 && q0.size() > 0) begin drive0(1'b1, q0[0]); act0 = 1'b1; end
        else if (!act0) drive0(1'b0, nox);
        if (!act1 && q1.size() > 0) begin drive1(1'b1, q1[0]); act1 = 1'b1; end
        else if (!act1) drive1(1'b0, nox);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_engine(input int limit);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || act0 || act1) && n < limit) begin
            tick();
            engine_tick();
            n++;
        end
        check_output("engine_done_in_budget", 32'(n < limit), 32'd1);
    endtask

    task automatic apply_stimulus_reset();
        tick();
        reset_n = 1'b0;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = 0; m1_address = 0; m0_byteenable = 0; m1_byteenable = 0;
        stall_all = 1'b0; wait_cfg = 0;
        act0 = 1'b0; act1 = 1'b0; q0.delete(); q1.delete();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n0;

        // Reset state
        tick(); #2;
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_bus_error", 32'(bus_error), 32'd0);
        check_output("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        check_output("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        check_output("rst_s_read", 32'(s_read), 32'd0);
        check_output("rst_s_address", s_address, 32'd0);
        tick();
        reset_n = 1'b1;

        // Single zero-wait read by master 0
        m0_read = 1'b1; m0_address = 32'h10; m0_byteenable = 4'hF;
        #2;
        check_output("t1_c1_m0_wait", 32'(m0_waitrequest), 32'd1);
        check_output("t1_c1_grant", 32'(grant), 32'd0);
        tick(); #2;
        check_output("t1_c2_grant", 32'(grant), 32'b01);
        check_output("t1_c2_s_read", 32'(s_read), 32'd1);
        check_output("t1_c2_m0_wait", 32'(m0_waitrequest), 32'd0);
        check_output("t1_c2_m0_readdata", m0_readdata, 32'hA500_0010);
        tick();
        m0_read = 1'b0;
        #2;
        check_output("t1_c3_grant", 32'(grant), 32'd0);

        // Simultaneous first requests: handoff without an idle cycle
        apply_stimulus_reset();
        comp.delete();
        add_xfer(0, 1'b1, 32'h20, 32'hCAFE_F00D);
        add_xfer(1, 1'b0, 32'h40, 32'h0);
        run_engine(50);
        check_output("t2_count", 32'(comp.size()), 32'd2);
        if (comp.size() == 2) begin
            check_output("t2_first_master", 32'(comp[0].m), 32'd0);
            check_output("t2_second_master", 32'(comp[1].m), 32'd1);
            check_output("t2_handoff_gap", 32'(comp[1].cyc - comp[0].cyc), 32'd1);
            check_output("t2_m1_data", comp[1].data, 32'hA500_0040);
        end
        comp.delete();
        add_xfer(0, 1'b0, 32'h20, 32'h0);
        run_engine(50);
        check_output("t2_readback_count", 32'(comp.size()), 32'd1);
        if (comp.size() == 1) check_output("t2_readback", comp[0].data, 32'hCAFE_F00D);

        // Fairness: both masters saturate the bus for 8 transfers
        apply_stimulus_reset();
        wait_cfg = 1;
        comp.delete();
        for (int i = 0; i < 4; i++) begin
            add_xfer(0, (i % 2) == 0, 32'h80 + 32'(8 * i), 32'h1000 + 32'(i));
            add_xfer(1, 1'b0, 32'h84 + 32'(8 * i), 32'h0);
        end
        run_engine(200);
        check_output("t3_total", 32'(comp.size()), 32'd8);
        n0 = 0;
        foreach (comp[i]) begin
            check_output($sformatf("t3_order_%0d", i), 32'(comp[i].m), 32'(i % 2));
            if (comp[i].m == 0) n0++;
        end
        check_output("t3_m0_completions", 32'(n0), 32'd4);
        wait_cfg = 0;

        // Timeout: slave never answers master 1
        stall_all = 1'b1;
        m1_read = 1'b1; m1_address = 32'h44; m1_byteenable = 4'hF;
        #2;
        check_output("t4_idle_grant", 32'(grant), 32'd0);
        check_output("t4_idle_wait", 32'(m1_waitrequest), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick(); #2;
            check_output($sformatf("t4_c%0d_grant", c), 32'(grant), 32'b10);
            check_output($sformatf("t4_c%0d_wait", c), 32'(m1_waitrequest), 32'd1);
        end
        tick(); #2;
        check_output("t4_abort_wait", 32'(m1_waitrequest), 32'd0);
        check_output("t4_abort_readdata", m1_readdata, 32'h0);
        check_output("t4_abort_s_read", 32'(s_read), 32'd0);
        tick();
        m1_read = 1'b0;
        #2;
        check_output("t4_error_set", 32'(bus_error), 32'd1);
        check_output("t4_after_grant", 32'(grant), 32'd0);
        stall_all = 1'b0;
        comp.delete();
        add_xfer(1, 1'b0, 32'h44, 32'h0);
        run_engine(50);
        check_output("t4_error_sticky", 32'(bus_error), 32'd1);
        if (comp.size() == 1) check_output("t4_later_read", comp[0].data, 32'hA500_0044);

        // Reset in the middle of a stalled master 1 transfer
        stall_all = 1'b1;
        tick();
        m1_read = 1'b1; m1_address = 32'h48; m1_byteenable = 4'hF;
        tick(); #2;
        check_output("t5_granted", 32'(grant), 32'b10);
        reset_n = 1'b0;
        #1;
        check_output("t5_rst_grant", 32'(grant), 32'd0);
        check_output("t5_rst_s_read", 32'(s_read), 32'd0);
        check_output("t5_rst_bus_error", 32'(bus_error), 32'd0);
        check_output("t5_rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        tick();
        stall_all = 1'b0;
        m0_read = 1'b1; m0_address = 32'h50; m0_byteenable = 4'hF;
        m1_address = 32'h54;
        reset_n = 1'b1;
        tick(); #2;
        check_output("t5_m0_wins", 32'(grant), 32'b01);
        tick();
        m0_read = 1'b0;
        #2;
        check_output("t5_m1_next", 32'(grant), 32'b10);
        tick();
        m1_read = 1'b0;
        tick();

        // Master 0 withdraws while stalled; pending master 1 follows
        apply_stimulus_reset();
        stall_all = 1'b1;
        m0_read = 1'b1; m0_address = 32'h30; m0_byteenable = 4'hF;
        m1_read = 1'b1; m1_address = 32'h34; m1_byteenable = 4'hF;
        tick(); #2;
        check_output("t6_m0_granted", 32'(grant), 32'b01);
        tick();
        m0_read = 1'b0;
        tick(); #2;
        check_output("t6_idle_after_drop", 32'(grant), 32'd0);
        check_output("t6_no_error", 32'(bus_error), 32'd0);
        tick(); #2;
        check_output("t6_m1_granted", 32'(grant), 32'b10);
        stall_all = 1'b0;
        tick();
        m1_read = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single memory slave (the `ram_tiny_CPU` memory model in simulation, real memory otherwise) between `mips_cpu_bus` (master 0) and a secondary master such as a loader or DMA engine (master 1). It uses the same read/write/waitrequest bus the CPU already speaks and grants one master at a time, round-robin. It holds each grant until the transfer completes and aborts transfers that stall beyond a timeout, raising a sticky error.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum granted cycles with slave `waitrequest` high before abort; legal range 2..65535.

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_address`, `m1_address` in 32: master byte addresses.
- `m0_read`, `m0_write`, `m1_read`, `m1_write` in 1: master requests. Read and write are never both high on one master.
- `m0_writedata`, `m1_writedata` in 32: write data.
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to each master.
- `m0_readdata`, `m1_readdata` out 32: read data to each master.
- `s_address` out 32, `s_read` out 1, `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4: slave side.
- `s_waitrequest` in 1, `s_readdata` in 32: slave responses.
- `bus_error` out 1: sticky timeout flag.
- `grant` out 2: one-hot current owner, `00` when idle. Debug/verification only.

## Operation
- Requesting master: `mX_read | mX_write`.
- FSM states (enum in package): `IDLE`, `GRANT0`, `GRANT1`.
- `IDLE`:
  - No request → stay.
  - One request → grant that master.
  - Both → grant the master not in `last_grant`.
  - `last_grant` resets to 1, so master 0 wins the first tie.
- `GRANTx`:
  - Slave outputs are combinationally routed from master x.
  - `mx_waitrequest = s_waitrequest`; `mx_readdata = s_readdata`.
  - The other master sees `waitrequest = 1` and `readdata = 0`.
- Completion: granted master requesting and `s_waitrequest == 0` on a rising edge.
  - `last_grant ← x`.
  - Next state: the other master's state if it is requesting, else `IDLE`.
  - No idle bubble when the other master is waiting.
  - The same master re-requesting immediately is not regranted if the other is pending.
- Granted master drops its request without completion (protocol violation): return to `IDLE`, `last_grant ← x`, no error.
- Timeout:
  - Counter clears on each new grant and increments each granted cycle with `s_waitrequest = 1`.
  - When it reaches `TIMEOUT_CYCLES - 1` with `s_waitrequest` still high, that cycle is an abort cycle:
    - granted master sees `waitrequest = 0` and `readdata = 32'h0000_0000`;
    - slave `s_read`/`s_write` are forced low;
    - `bus_error ← 1`;
    - FSM proceeds as on completion.
- `bus_error` clears only on reset.
- When idle, slave outputs are `s_read = s_write = 0`, with address, writedata and byteenable all zero.

## Timing
- Reset (async assert) forces these values immediately:
  - FSM `IDLE`, `grant = 00`, `last_grant = 1`, timeout counter 0, `bus_error = 0`.
  - `s_read = s_write = 0`, `s_address = 0`, `s_writedata = 0`, `s_byteenable = 0`.
  - `m0_waitrequest = m1_waitrequest = 1`, `m0_readdata = m1_readdata = 0`.
- Reset deassertion is synchronous to `clk`. An in-flight transfer is dropped with no completion signalled.
- Arbitration latency: a request arriving in `IDLE` sees `waitrequest = 1` for exactly 1 cycle before the slave sees it.
- Routing is combinational in `GRANTx`, so the slave's own latency adds directly.
- Back-to-back handoff between masters: 0 idle cycles.
- Single-master back-to-back: 1 `IDLE` cycle between transfers.
- Grant is registered. No combinational path from `mX_read`/`mX_write` to `grant`.

## Structure
- `mem_bus_pkg`:
  - `arb_state_t` enum;
  - `ABORT_READDATA = 32'h0`;
  - bus field widths (`ADDR_W = 32`, `DATA_W = 32`, `BE_W = 4`).
- Single module; no sub-module needed. The slave-side mux is an `always_comb` on the state.
- Counter width: `$clog2(TIMEOUT_CYCLES)`.

## Test plan
- Single read, master 0, zero-wait slave: M0 reads address 0x0000_0010.
  - Cycle 1: `m0_waitrequest = 1`, `grant = 00`.
  - Cycle 2: `grant = 01`, `s_read = 1`, `m0_readdata` = slave word, `m0_waitrequest = 0`.
  - Cycle 3: `IDLE`.
- Simultaneous first requests:
  - M0 writes 0xCAFEF00D to 0x20 while M1 reads 0x40.
  - M0 is granted first; M1 is granted the cycle after M0 completes, with no idle cycle.
  - Read of 0x20 afterwards returns 0xCAFEF00D.
- Fairness: both masters request continuously for 8 transfers.
  - `grant` alternates 01,10,01,...
  - Each master gets exactly 4 completions.
- Timeout: `TIMEOUT_CYCLES = 4`, slave holds `s_waitrequest = 1`, M1 reads.
  - On the 4th granted cycle: `m1_waitrequest = 0`, `m1_readdata = 0`, `bus_error = 1`.
  - `bus_error` stays 1 through later successful transfers.
- Reset mid-transfer: assert `reset_n = 0` while in `GRANT1` with the slave stalling.
  - Same cycle, before the next edge: `grant = 00`, `s_read = 0`, `bus_error = 0`.
  - After release, M0 and M1 both request: M0 wins.
- Request withdrawal: M0 drops `m0_read` while granted and stalled.
  - FSM returns to `IDLE` next cycle; `bus_error` stays 0.
  - A pending M1 is granted on the following cycle.
